// File: rtl/dac_spi_arbiter.sv
// Round-robin arbiter sharing one LTC2624 SPI DAC between four requesters.
// Builds the 32-bit command frame, sequences CS/SCK/MOSI and drives the power-up DAC_CLR pulse.
module dac_spi_arbiter #(
    parameter int CLKDIV     = 2,
    parameter int CLR_CYCLES = 16,
    parameter int CS_GAP     = 4
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic [3:0]  req,
    input  logic [15:0] cmd,
    input  logic [47:0] data,
    output logic [3:0]  ack,
    output logic        busy,
    output logic [1:0]  grant_idx,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    output logic        DAC_CS,
    output logic        DAC_CLR
);

    localparam int CNT_MAX = (CLR_CYCLES > CS_GAP)
                           ? ((CLR_CYCLES > CLKDIV) ? CLR_CYCLES : CLKDIV)
                           : ((CS_GAP > CLKDIV) ? CS_GAP : CLKDIV);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLKDIV - 1);

    typedef enum logic [2:0] {S_CLR, S_GAP, S_IDLE, S_SETUP, S_SHIFT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      bit_q, bit_d;
    logic [31:0]     sreg_q, sreg_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic [3:0]      ack_q, ack_d;
    logic            sck_q, sck_d;
    logic            cs_q, cs_d;
    logic            clr_q, clr_d;

    logic [3:0]      cmd_a  [4];
    logic [11:0]     data_a [4];
    logic            found;
    logic [1:0]      pick;
    logic [1:0]      cand;
    logic [31:0]     frame;

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign cmd_a[g]  = cmd[4*g +: 4];
        assign data_a[g] = data[12*g +: 12];
    end

    // Search order starts just after the last grant, so the last winner goes to the back.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign frame = {8'h00, cmd_a[pick], 2'b00, pick, data_a[pick], 4'h0};

    // NOTE: every *_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        last_d  = last_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        ack_d   = '0;
        sck_d   = sck_q;
        cs_d    = cs_q;
        clr_d   = clr_q;

        unique case (state_q)
            S_CLR: begin
                if (cnt_q == CLR_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    clr_d   = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (found) begin
                    state_d = S_SETUP;
                    sreg_d  = frame;
                    cs_d    = 1'b0;
                    grant_d = pick;
                    last_d  = pick;
                    busy_d  = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sck_q) begin
                        // Falling edge: present the next bit half a period before the DAC samples it.
                        sck_d  = 1'b0;
                        sreg_d = {sreg_q[30:0], 1'b0};
                    end else if (bit_q == 5'd31) begin
                        state_d        = S_DONE;
                        cs_d           = 1'b1;
                        ack_d[grant_q] = 1'b1;
                    end else begin
                        sck_d = 1'b1;
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            default: state_d = S_CLR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state_q <= S_CLR;
            cnt_q   <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            last_q  <= 2'd3;
            grant_q <= '0;
            busy_q  <= 1'b1;
            ack_q   <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            clr_q   <= clr_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign grant_idx = grant_q;
    assign SPI_SCK   = sck_q;
    assign SPI_MOSI  = sreg_q[31];
    assign DAC_CS    = cs_q;
    assign DAC_CLR   = clr_q;

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Directed bench for dac_spi_arbiter: a behavioural LTC2624 shift register plus CS/ack
// monitors, driven by a linear sequence of steps with hand-computed expected values.
module tb_dac_spi_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] cmd;
    logic [47:0] data;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  grant_idx;
    logic        spi_sck;
    logic        spi_mosi;
    logic        dac_cs;
    logic        dac_clr;

    int compared   = 0;
    int mismatched = 0;

    always #10 clk = ~clk;

    dac_spi_arbiter #(.CLKDIV(2), .CLR_CYCLES(16), .CS_GAP(4)) dut (
        .CLK50MHZ  (clk),
        .RST       (rst_n),
        .req       (req),
        .cmd       (cmd),
        .data      (data),
        .ack       (ack),
        .busy      (busy),
        .grant_idx (grant_idx),
        .SPI_SCK   (spi_sck),
        .SPI_MOSI  (spi_mosi),
        .DAC_CS    (dac_cs),
        .DAC_CLR   (dac_clr)
    );

    // Behavioural DAC: samples MOSI on SCK rise while CS is low, keeps only full 32-bit words.
    int          dac_bits = 0;
    logic [31:0] dac_sr   = '0;
    logic [31:0] dac_words[$];

    always @(negedge dac_cs) dac_bits = 0;
    always @(posedge spi_sck) if (dac_cs === 1'b0) begin
        dac_sr   = {dac_sr[30:0], spi_mosi};
        dac_bits = dac_bits + 1;
    end
    always @(posedge dac_cs) begin
        if (dac_bits == 32) dac_words.push_back(dac_sr);
        dac_bits = 0;
    end

    // Cycle monitors sampled on the falling clock edge.
    int   ack_log[$];
    int   ack_bad    = 0;
    int   sck_bad    = 0;
    int   cs_low_run = 0;
    int   cs_hi_run  = 0;
    int   last_low   = 0;
    int   min_gap    = 1000;
    bit   seen_frame = 1'b0;
    logic prev_cs    = 1'b1;
    logic prev_ack   = 1'b0;

    always @(negedge clk) begin
        if (ack !== 4'b0000) begin
            if ($onehot(ack) && dac_cs === 1'b1 && prev_cs === 1'b0 && !prev_ack) begin
                for (int i = 0; i < 4; i++) if (ack[i]) ack_log.push_back(i);
            end else begin
                ack_bad = ack_bad + 1;
            end
        end
        if (spi_sck === 1'b1 && dac_cs === 1'b1) sck_bad = sck_bad + 1;
        if (dac_cs === 1'b0) begin
            if (cs_hi_run > 0 && seen_frame && cs_hi_run < min_gap) min_gap = cs_hi_run;
            cs_hi_run  = 0;
            cs_low_run = cs_low_run + 1;
        end else begin
            if (cs_low_run > 0) begin
                last_low   = cs_low_run;
                seen_frame = 1'b1;
            end
            cs_low_run = 0;
            cs_hi_run  = cs_hi_run + 1;
        end
        prev_cs  = dac_cs;
        prev_ack = |ack;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_acks(input string tag, input int n, input int budget);
        int t = 0;
        while (ack_log.size() < n && t < budget) begin
            tick();
            t++;
        end
        check(tag, 32'(ack_log.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy !== 1'b0 && t < 200) begin
            tick();
            t++;
        end
        check(tag, 32'(busy), 32'h0);
    endtask

    task automatic measure_clr(input string tag);
        int n = 0;
        while (dac_clr !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req   = 4'b0000;
        cmd   = '0;
        data  = '0;

        // Reset state and the power-up clear sequence.
        repeat (5) tick();
        check("rst_ack",   32'(ack),       32'h0);
        check("rst_busy",  32'(busy),      32'h1);
        check("rst_grant", 32'(grant_idx), 32'h0);
        check("rst_sck",   32'(spi_sck),   32'h0);
        check("rst_mosi",  32'(spi_mosi),  32'h0);
        check("rst_cs",    32'(dac_cs),    32'h1);
        check("rst_clr",   32'(dac_clr),   32'h0);
        rst_n = 1'b1;
        measure_clr("clr_low_cycles");
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check("gap_cycles", 32'(n), 32'd4);
        check("idle_cs",    32'(dac_cs), 32'h1);
        check("idle_acks",  32'(ack_log.size()), 32'h0);

        // Round-robin with all four requesting: 0,1,2,3,0.
        cmd  = 16'h3333;
        data = 48'h444_333_222_111;
        req  = 4'b1111;
        wait_acks("rr_wait", 5, 1000);
        req = 4'b0000;
        check("rr_ack0", 32'(ack_log[0]), 32'd0);
        check("rr_ack1", 32'(ack_log[1]), 32'd1);
        check("rr_ack2", 32'(ack_log[2]), 32'd2);
        check("rr_ack3", 32'(ack_log[3]), 32'd3);
        check("rr_ack4", 32'(ack_log[4]), 32'd0);
        check("rr_word0", dac_words[0], 32'h0030_1110);
        check("rr_word1", dac_words[1], 32'h0031_2220);
        check("rr_word2", dac_words[2], 32'h0032_3330);
        check("rr_word3", dac_words[3], 32'h0033_4440);
        check("rr_word4", dac_words[4], 32'h0030_1110);
        check("rr_gap_ge4", 32'(min_gap >= 4), 32'h1);
        wait_idle("rr_idle");

        // Single write from requester 1.
        cmd  = 16'h0030;
        data = 48'h000_000_ABC_000;
        req  = 4'b0010;
        wait_acks("single_wait", 6, 400);
        req = 4'b0000;
        check("single_ack",   32'(ack_log[5]), 32'd1);
        check("single_word",  dac_words[5], 32'h0031_ABC0);
        check("single_cslow", 32'(last_low), 32'd130);
        check("single_grant", 32'(grant_idx), 32'd1);
        wait_idle("single_idle");
        check("grant_hold", 32'(grant_idx), 32'd1);

        // Pointer fairness: after serving 2, a 0/2 pair goes to 0 first.
        cmd  = 16'h0300;
        data = 48'h000_555_000_000;
        req  = 4'b0100;
        wait_acks("ptr_wait2", 7, 400);
        req = 4'b0000;
        check("ptr_ack2", 32'(ack_log[6]), 32'd2);
        wait_idle("ptr_idle");
        cmd  = 16'h0303;
        data = 48'h000_777_000_666;
        req  = 4'b0101;
        tick();
        check("ptr_grant0", 32'(grant_idx), 32'd0);
        wait_acks("ptr_wait0", 8, 400);
        req = 4'b0100;
        wait_acks("ptr_wait2b", 9, 400);
        req = 4'b0000;
        check("ptr_order0", 32'(ack_log[7]), 32'd0);
        check("ptr_order2", 32'(ack_log[8]), 32'd2);
        check("ptr_word0",  dac_words[7], 32'h0030_6660);
        check("ptr_word2",  dac_words[8], 32'h0032_7770);
        wait_idle("ptr_idle2");

        // Inputs changing mid-frame do not disturb the latched frame.
        cmd  = 16'h0003;
        data = 48'h000_000_000_123;
        req  = 4'b0001;
        repeat (40) tick();
        data[11:0] = 12'hFFF;
        cmd[3:0]   = 4'hF;
        wait_acks("latch_wait", 10, 400);
        req = 4'b0000;
        check("latch_word", dac_words[9], 32'h0030_1230);
        wait_idle("latch_idle");

        // Reset at bit 10 aborts the frame without an ack and reruns the clear pulse.
        cmd  = 16'h0030;
        data = 48'h000_000_ABC_000;
        req  = 4'b0010;
        n = 0;
        while (dac_bits < 10 && n < 200) begin
            tick();
            n++;
        end
        check("abort_reach", 32'(dac_bits), 32'd10);
        rst_n = 1'b0;
        #1;
        check("abort_cs",   32'(dac_cs),  32'h1);
        check("abort_sck",  32'(spi_sck), 32'h0);
        check("abort_clr",  32'(dac_clr), 32'h0);
        check("abort_busy", 32'(busy),    32'h1);
        req = 4'b0000;
        repeat (3) tick();
        check("abort_no_write", 32'(dac_words.size()), 32'd10);
        rst_n = 1'b1;
        measure_clr("abort_clr_low");
        wait_idle("abort_idle");
        check("abort_no_ack", 32'(ack_log.size()), 32'd10);
        check("sck_while_cs", 32'(sck_bad), 32'd0);
        check("ack_shape",    32'(ack_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dac_spi_arbiter.md
Name: dac_spi_arbiter

Overview:
- Shares the single LTC2624 SPI DAC between four requesters, arbitrating round-robin between them.
- For each granted request, builds the 32-bit LTC2624 command frame and sequences CS, SCK and MOSI.
- Drives the power-up DAC_CLR pulse.
- Sits between application logic (button/switch control, waveform generators) and the DAC pins in Top.

Parameters:
- CLKDIV, 2: SCK half-period in clock cycles (>=1); the default gives 12.5 MHz SCK from 50 MHz.
- CLR_CYCLES, 16: cycles DAC_CLR is held low after reset release.
- CS_GAP, 4: minimum cycles DAC_CS stays high between frames.

Ports:
- CLK50MHZ  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- req  in  4  request per requester i (level; hold until ack[i]).
- cmd  in  16  4-bit LTC2624 command per requester, cmd[4i+3:4i].
- data  in  48  12-bit code per requester, data[12i+11:12i].
- ack  out  4  one-cycle pulse to requester i when its frame completes.
- busy  out  1  high from grant until the CS_GAP period ends.
- grant_idx  out  2  index of the current/last granted requester.
- SPI_SCK  out  1  DAC serial clock.
- SPI_MOSI  out  1  DAC serial data.
- DAC_CS  out  1  DAC chip select, active low.
- DAC_CLR  out  1  DAC clear, active low.

Behaviour:
- Reset (RST=0, async):
  - ack=0, busy=1, grant_idx=0.
  - SPI_SCK=0, SPI_MOSI=0, DAC_CS=1, DAC_CLR=0.
  - Round-robin pointer last=3, so requester 0 has first priority.
  - State=CLR.
- CLR: DAC_CLR stays 0 for CLR_CYCLES cycles after RST rises, then goes 1. Next state is GAP.
- GAP: DAC_CS=1 for CS_GAP cycles. Next state is IDLE; busy=0 on entry to IDLE.
- IDLE:
  - If any req bit is set, grant the first set bit searching last+1, last+2, ... modulo 4.
  - Grant cycle actions:
    - Latch frame = {8'h00, cmd[i], 4'(i), data[i], 4'h0}; address = requester index.
    - Set grant_idx=i and last=i; busy=1.
    - Next state is SETUP.
  - With no req set, stay in IDLE.
- SETUP:
  - DAC_CS=0 and SPI_MOSI=frame[31], held for CLKDIV cycles.
  - Next state is SHIFT.
- SHIFT, 32 bits MSB first:
  - SCK toggles every CLKDIV cycles, starting high.
  - The DAC samples MOSI on the SCK rising edge.
  - MOSI updates to the next bit CLKDIV cycles after each rising edge, coincident with SCK falling.
  - After the 32nd falling edge, SCK=0; next state is DONE.
- DONE:
  - DAC_CS=1 and ack[grant_idx]=1 for exactly one cycle.
  - Next state is GAP.
- Frame length: 2 + 32*2 + ... = CLKDIV*(1+64) cycles of CS low. With CLKDIV=2 that is 130 cycles.
- Latched frame: req/cmd/data changes after the grant do not affect the frame in flight.
  - A req dropped after grant still completes and still acks.
  - A req dropped before grant is never served.
- Requests arriving during CLR/SETUP/SHIFT/DONE/GAP wait and are arbitrated in IDLE. No request is lost while its req stays high.
- Fairness: with all four req high, the grant order is 0,1,2,3,0,... No requester waits more than 3 frames.
- Simultaneous events: a req rising in the DONE cycle is arbitrated no earlier than the first IDLE cycle. A requester re-asserting req the cycle after its ack is treated as a new request behind the others.
- Reset mid-frame: outputs go immediately to reset values, so DAC_CS=1 aborts the frame with no ack. After release the CLR sequence reruns.
- grant_idx holds its value between frames.
- SCK is never high while DAC_CS=1.

Test Plan:
- Reset then idle: RST low 5 cycles, release -> DAC_CLR=0 for 16 cycles then 1; DAC_CS=1; busy falls after a further 4 cycles; ack=0.
- Single write: req=4'b0010, cmd[7:4]=4'h3, data[23:12]=12'hABC -> one CS-low window of 130 cycles; behavioural DAC decodes 32'h0031ABC0; ack[1] is a single pulse in the cycle CS rises; grant_idx=1.
- Round-robin: req=4'b1111 held -> ack order 0,1,2,3,0; consecutive CS windows separated by >=4 high cycles.
- Pointer fairness: serve requester 2, then assert req=4'b0101 -> requester 0 is granted before 2.
- Data change mid-frame: change data[11:0] from 12'h123 to 12'hFFF during SHIFT -> the frame carries 12'h123.
- Reset mid-frame: assert RST at bit 10 of SHIFT -> DAC_CS=1 and SCK=0 immediately; no ack; DAC model reports no completed write; CLR pulse repeats after release.
